// File: rtl/dmux_8_way_16_buf.sv
// dmux_8_way_16_buf: registered 8-way demultiplexer with valid/ready handshakes.
// A single upstream word stream is steered by in_sel to one of eight channels.
// Each channel keeps the word in a one-entry buffer until its consumer takes it.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset; clears every buffer at once
//   in_data    word to route (WIDTH bits)
//   in_sel     destination channel index 0..7
//   in_valid   producer offers in_data/in_sel
//   in_ready   the selected slot can take a word this cycle (combinational)
//   in_bcast   (DMUX_BROADCAST_EN only) send the word to all eight channels
//   out_data   channel i word on [i*WIDTH +: WIDTH]
//   out_valid  bit i set while channel i holds a word
//   out_ready  bit i: consumer i takes its word this cycle
//   busy       OR of out_valid
//
// Build option: define DMUX_BROADCAST_EN to add the in_bcast port.

// One channel buffer: a load wins over a drain, so a same-cycle
// drain-and-load leaves the slot full with the new word.
module dmux_8_way_16_buf_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_q,
  output logic             valid_q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= in_data;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      // data_q keeps its last value after the word is taken
      valid_q <= 1'b0;
    end
  end
endmodule

module dmux_8_way_16_buf #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8   // tied to the 3-bit in_sel
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [2:0]                in_sel,
  input  logic                      in_valid,
`ifdef DMUX_BROADCAST_EN
  input  logic                      in_bcast,
`endif
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      busy
);

  logic [CHANNELS-1:0][WIDTH-1:0] data_q;
  logic [CHANNELS-1:0]            valid_q;
  logic [CHANNELS-1:0]            slot_free;
  logic [CHANNELS-1:0]            load;
  logic                           accept;

  // A slot is free when empty or when its current word leaves this cycle.
  assign slot_free = ~valid_q | out_ready;

`ifdef DMUX_BROADCAST_EN
  assign in_ready = in_bcast ? (&slot_free) : slot_free[in_sel];
`else
  assign in_ready = slot_free[in_sel];
`endif

  assign accept = in_valid && in_ready;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_lane
`ifdef DMUX_BROADCAST_EN
      assign load[i] = accept && (in_bcast || (in_sel == 3'(i)));
`else
      assign load[i] = accept && (in_sel == 3'(i));
`endif
      dmux_8_way_16_buf_lane #(.WIDTH(WIDTH)) u_lane (
        .clk       (clk),
        .reset     (reset),
        .load      (load[i]),
        .in_data   (in_data),
        .out_ready (out_ready[i]),
        .data_q    (data_q[i]),
        .valid_q   (valid_q[i])
      );
    end
  endgenerate

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = |valid_q;

endmodule

// File: tb/tb_dmux_8_way_16_buf.sv
module tb_dmux_8_way_16_buf;
  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  in_data;
  logic [2:0]   in_sel;
  logic         in_valid;
  logic         in_bcast;
  logic         in_ready;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic         busy;

  int nvec = 0;
  int nerr = 0;

  // reference state: what each consumer should currently see
  logic [15:0] mdata [8];
  logic        mvalid[8];

  always #5 clk = ~clk;

  dmux_8_way_16_buf dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
`ifdef DMUX_BROADCAST_EN
    .in_bcast  (in_bcast),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [15:0] d;
    logic [7:0]  rdy;
    logic        exp_ir;
    logic [7:0]  exp_ov;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic [2:0] s, input logic [7:0] r, input logic b);
    logic all_free = 1'b1;
    for (int k = 0; k < 8; k++) all_free &= (!mvalid[k] || r[k]);
    return b ? all_free : (!mvalid[s] || r[s]);
  endfunction

  function automatic logic [127:0] model_data();
    logic [127:0] x = '0;
    for (int k = 0; k < 8; k++) x[k*16 +: 16] = mdata[k];
    return x;
  endfunction

  function automatic logic [7:0] model_valid();
    logic [7:0] x = '0;
    for (int k = 0; k < 8; k++) x[k] = mvalid[k];
    return x;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin mdata[k] = '0; mvalid[k] = 1'b0; end
  endtask

  // Drive one cycle (inputs change 1ns after an edge), check the combinational
  // ready, clock it, advance the model and check every output.
  task automatic cycle(input logic v, input logic [2:0] s, input logic [15:0] d,
                       input logic [7:0] r, input logic b,
                       input logic hand, input logic hir, input logic [7:0] hov);
    logic eir, acc;
    in_valid = v; in_sel = s; in_data = d; out_ready = r; in_bcast = b;
    #1;
    eir = model_ready(s, r, in_bcast);
    chk("in_ready", {127'b0, in_ready}, {127'b0, eir});
    if (hand) chk("tbl_in_ready", {127'b0, in_ready}, {127'b0, hir});
    acc = v && eir;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (acc && (in_bcast || s == 3'(k))) begin
        mdata[k] = d; mvalid[k] = 1'b1;
      end else if (mvalid[k] && r[k]) begin
        mvalid[k] = 1'b0;
      end
    end
    #1;
    chk("out_valid", {120'b0, out_valid}, {120'b0, model_valid()});
    chk("out_data", out_data, model_data());
    chk("busy", {127'b0, busy}, {127'b0, |model_valid()});
    if (hand) chk("tbl_out_valid", {120'b0, out_valid}, {120'b0, hov});
  endtask

  vec_t tbl[$];

  initial begin
    model_clear();
    reset = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0;
    in_bcast = 1'b0; out_ready = '0;
    #12;
    chk("rst_out_valid", {120'b0, out_valid}, 128'h0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_busy", {127'b0, busy}, 128'h0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'h1);
    reset = 1'b0;
    @(posedge clk); #1;

    // streaming, one word per channel with every consumer ready
    tbl.push_back('{1, 0, 16'h5555, 8'hFF, 1, 8'h01});
    tbl.push_back('{1, 1, 16'h1111, 8'hFF, 1, 8'h02});
    tbl.push_back('{1, 2, 16'h2222, 8'hFF, 1, 8'h04});
    tbl.push_back('{1, 3, 16'h3333, 8'hFF, 1, 8'h08});
    tbl.push_back('{1, 4, 16'h4444, 8'hFF, 1, 8'h10});
    tbl.push_back('{1, 5, 16'h6666, 8'hFF, 1, 8'h20});
    tbl.push_back('{1, 6, 16'h7777, 8'hFF, 1, 8'h40});
    tbl.push_back('{1, 7, 16'hF0F0, 8'hFF, 1, 8'h80});
    tbl.push_back('{0, 0, 16'h0000, 8'hFF, 1, 8'h00});
    // channel 3 stall, then drain-and-load on release
    tbl.push_back('{1, 3, 16'hAAAA, 8'hF7, 1, 8'h08});
    tbl.push_back('{1, 3, 16'hBBBB, 8'hF7, 0, 8'h08});
    tbl.push_back('{1, 3, 16'hBBBB, 8'hFF, 1, 8'h08});
    tbl.push_back('{0, 3, 16'h0000, 8'hFF, 1, 8'h00});
    // channel 2 stalled does not block channel 5
    tbl.push_back('{1, 2, 16'h0202, 8'h00, 1, 8'h04});
    tbl.push_back('{1, 5, 16'h1234, 8'h00, 1, 8'h24});
    tbl.push_back('{1, 2, 16'h9999, 8'h00, 0, 8'h24});
    // two drains alongside one load
    tbl.push_back('{0, 0, 16'h0000, 8'hFF, 1, 8'h00});
    tbl.push_back('{1, 0, 16'h0001, 8'h00, 1, 8'h01});
    tbl.push_back('{1, 7, 16'h0080, 8'h00, 1, 8'h81});
    tbl.push_back('{1, 4, 16'h00FF, 8'h81, 1, 8'h10});
    tbl.push_back('{0, 0, 16'h0000, 8'hFF, 1, 8'h00});

    foreach (tbl[n])
      cycle(tbl[n].v, tbl[n].sel, tbl[n].d, tbl[n].rdy, 1'b0, 1'b1, tbl[n].exp_ir, tbl[n].exp_ov);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++)
      cycle(1'($urandom), 3'($urandom), 16'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 8'h0);

    // asynchronous reset with channels 0 and 2 full
    cycle(0, 0, 16'h0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00);
    cycle(1, 0, 16'hC0C0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01);
    cycle(1, 2, 16'hC2C2, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05);
    in_valid = 1'b0; in_sel = 3'd0; out_ready = 8'h00;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {120'b0, out_valid}, 128'h0);
    chk("mid_rst_busy", {127'b0, busy}, 128'h0);
    chk("mid_rst_in_ready", {127'b0, in_ready}, 128'h1);
    chk("mid_rst_out_data", out_data, 128'h0);
    #1;
    reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    cycle(1, 1, 16'hD1D1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02);
    cycle(0, 0, 16'h0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00);

`ifdef DMUX_BROADCAST_EN
    cycle(1, 6, 16'h0606, 8'h00, 1'b0, 1'b1, 1'b1, 8'h40);
    cycle(1, 0, 16'h3333, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40);
    cycle(1, 0, 16'h3333, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF);
    chk("bcast_data", out_data, {8{16'h3333}});
    cycle(0, 0, 16'h0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int n = 0; n < 200; n++)
      cycle(1'($urandom), 3'($urandom), 16'($urandom), 8'($urandom),
            1'($urandom_range(0, 3) == 0), 1'b0, 1'b0, 8'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
